// File: rtl/hex_display_arbiter_if.sv
// Requester/display bundle for the hex display arbiter.
// Requesters drive i_req/i_data; the arbiter returns the grant and the
// value for the display stage.
interface hex_display_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    i_req;
  logic [16*N_REQ-1:0] i_data;
  logic [N_REQ-1:0]    o_grant;
  logic [OWN_W-1:0]    o_owner;
  logic                o_valid;
  logic [15:0]         o_data;
  logic                o_switch;

  modport master (
    output i_req, i_data,
    input  o_grant, o_owner, o_valid, o_data, o_switch
  );

  modport slave (
    input  i_req, i_data,
    output o_grant, o_owner, o_valid, o_data, o_switch
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin time-slicing arbiter for the shared 4-digit hex display path.
// Each owner keeps the display for DWELL cycles or until it drops its
// request; the winning 16-bit value is registered toward the display stage.
module hex_display_arbiter #(
  parameter int          N_REQ     = 4,
  parameter int          DWELL     = 50_000_000,
  parameter logic [15:0] BLANK_VAL = 16'h0000
) (
  input logic             clk,
  input logic             rst,
  hex_display_arbiter_if.slave bus
);
  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  // Control state
  logic [0:0]       state_p0;
  logic [OWN_W-1:0] last_p0;
  logic [CNT_W-1:0] cnt_p0;

  // Registered outputs
  logic [N_REQ-1:0] grant_p1;
  logic [OWN_W-1:0] owner_p1;
  logic             vld_p1;
  logic [15:0]      data_p1;
  logic             switch_p1;

  // Arbitration results
  logic [OWN_W-1:0] base;
  logic [OWN_W-1:0] win;
  logic             win_ok;
  logic             release_now;
  logic [OWN_W-1:0] cand;
  int               idx;

  function automatic logic [15:0] pick_slice(input logic [16*N_REQ-1:0] d,
                                             input logic [OWN_W-1:0]   s);
    logic [15:0] r;
    r = BLANK_VAL;
    for (int j = 0; j < N_REQ; j++) begin
      if (OWN_W'(j) == s) r = d[16*j +: 16];
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [OWN_W-1:0] s);
    logic [N_REQ-1:0] g;
    g = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (OWN_W'(j) == s) g[j] = 1'b1;
    end
    return g;
  endfunction

  // Rotate-priority scan starting just after base, base itself checked last.
  always_comb begin
    base   = (state_p0 == ST_SHOW) ? owner_p1 : last_p0;
    win    = '0;
    win_ok = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(base) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = OWN_W'(idx);
      if (!win_ok && bus.i_req[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
    end
    release_now = (state_p0 == ST_SHOW) &&
                  ((cnt_p0 == '0) || !bus.i_req[owner_p1]);
  end

  // Grant FSM, dwell counter and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= ST_IDLE;
      last_p0   <= OWN_W'(N_REQ - 1);
      cnt_p0    <= '0;
      grant_p1  <= '0;
      owner_p1  <= '0;
      vld_p1    <= 1'b0;
      data_p1   <= BLANK_VAL;
      switch_p1 <= 1'b0;
    end else if (state_p0 == ST_IDLE) begin
      if (win_ok) begin
        state_p0  <= ST_SHOW;
        last_p0   <= win;
        cnt_p0    <= CNT_LOAD;
        grant_p1  <= one_hot(win);
        owner_p1  <= win;
        vld_p1    <= 1'b1;
        data_p1   <= pick_slice(bus.i_data, win);
        switch_p1 <= 1'b1;
      end else begin
        data_p1   <= BLANK_VAL;
        switch_p1 <= 1'b0;
      end
    end else if (release_now) begin
      if (!win_ok) begin
        // Nobody left: blank the display, last keeps the released owner.
        state_p0  <= ST_IDLE;
        cnt_p0    <= '0;
        grant_p1  <= '0;
        owner_p1  <= '0;
        vld_p1    <= 1'b0;
        data_p1   <= BLANK_VAL;
        switch_p1 <= 1'b0;
      end else begin
        last_p0   <= win;
        cnt_p0    <= CNT_LOAD;
        grant_p1  <= one_hot(win);
        owner_p1  <= win;
        data_p1   <= pick_slice(bus.i_data, win);
        switch_p1 <= (win != owner_p1);
      end
    end else begin
      cnt_p0    <= cnt_p0 - 1'b1;
      data_p1   <= pick_slice(bus.i_data, owner_p1);
      switch_p1 <= 1'b0;
    end
  end

  assign bus.o_grant  = grant_p1;
  assign bus.o_owner  = owner_p1;
  assign bus.o_valid  = vld_p1;
  assign bus.o_data   = data_p1;
  assign bus.o_switch = switch_p1;
endmodule
